// File: rtl/pbvi_loop_ctrl_if.sv
// PBVI loop-controller bus: solve request, alpha capture, results.
// master = driver of start/en_loop/alpha_in/action_in; slave = controller.
interface pbvi_loop_ctrl_if #(
  parameter int N_POINTS = 16,
  parameter int N_STATES = 2,
  parameter int W        = 16
);
  logic                                    start;
  logic                                    en_loop;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_in;
  logic [N_POINTS-1:0][1:0]                action_in;
  logic                                    step_en;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_set;
  logic [N_POINTS-1:0][1:0]                policy;
  logic [7:0]                              iter_cnt;
  logic                                    busy;
  logic                                    done;
  logic                                    converged;
  logic                                    timeout;

  modport master (
    output start, en_loop, alpha_in, action_in,
    input  step_en, alpha_set, policy, iter_cnt,
    input  busy, done, converged, timeout
  );

  modport slave (
    input  start, en_loop, alpha_in, action_in,
    output step_en, alpha_set, policy, iter_cnt,
    output busy, done, converged, timeout
  );
endinterface

// File: rtl/pbvi_loop_ctrl.sv
// PBVI iteration controller + alpha-set store (IDLE/KICK/WAIT/CMP/DONE).
// Ports: clk, rst_n, bus (slave). Macro PBVI_LOOP_TIMEOUT_EN adds WAIT watchdog.
module pbvi_loop_ctrl #(
  parameter int             N_POINTS = 16,
  parameter int             N_STATES = 2,
  parameter int             W        = 16,
  parameter int             MAX_ITER = 64,
  parameter logic [W-1:0]   EPS      = 16'd4,
  parameter int             TIMEOUT  = 255
) (
  input logic              clk,
  input logic              rst_n,
  pbvi_loop_ctrl_if.slave  bus
);

  localparam int IW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  typedef enum logic [2:0] {
    IDLE, KICK, WAIT, CMP, DONE
  } state_t;

  typedef logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_t;
  typedef logic [N_POINTS-1:0][1:0]                 pol_t;

  state_t     state;
  alpha_t     alpha_set;
  alpha_t     alpha_new;
  pol_t       policy;
  pol_t       pol_new;
  logic [W-1:0]  max_delta;
  logic [IW-1:0] idx;
  logic [7:0] iter_cnt;
  logic       step_en;
  logic       done;
  logic       busy;
  logic       converged;

  logic [W-1:0] pt_max;
  logic [W-1:0] fin_max;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] d;
  logic         last;
  logic [7:0]   iter_nxt;

  // max |new-old| over the states of the current point, folded
  // with the running max so the last point is included in the test
  always_comb begin
    pt_max = '0;
    a      = '0;
    b      = '0;
    d      = '0;
    for (int s = 0; s < N_STATES; s++) begin
      a = alpha_new[idx][s];
      b = alpha_set[idx][s];
      d = (a >= b) ? a - b : b - a;
      if (d > pt_max) pt_max = d;
    end
    fin_max  = (max_delta > pt_max) ? max_delta : pt_max;
    last     = (idx == IW'(N_POINTS - 1));
    iter_nxt = iter_cnt + 8'd1;
  end

`ifdef PBVI_LOOP_TIMEOUT_EN
  logic [7:0] wcnt;
  logic       timeout_q;
  assign bus.timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign bus.timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alpha_set <= '0;
      alpha_new <= '0;
      policy    <= '0;
      pol_new   <= '0;
      max_delta <= '0;
      idx       <= '0;
      iter_cnt  <= '0;
      step_en   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      converged <= 1'b0;
`ifdef PBVI_LOOP_TIMEOUT_EN
      wcnt      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      step_en <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            iter_cnt  <= '0;
            converged <= 1'b0;
`ifdef PBVI_LOOP_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            step_en   <= 1'b1;
            busy      <= 1'b1;
            state     <= KICK;
          end
        end
        KICK: begin
`ifdef PBVI_LOOP_TIMEOUT_EN
          wcnt  <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (bus.en_loop) begin
            alpha_new <= bus.alpha_in;
            pol_new   <= bus.action_in;
            max_delta <= '0;
            idx       <= '0;
            state     <= CMP;
`ifdef PBVI_LOOP_TIMEOUT_EN
          end else if (wcnt == 8'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            wcnt <= wcnt + 8'd1;
`endif
          end
        end
        CMP: begin
          max_delta <= fin_max;
          idx       <= idx + IW'(1);
          if (last) begin
            alpha_set <= alpha_new;
            policy    <= pol_new;
            iter_cnt  <= iter_nxt;
            if (fin_max <= EPS) begin
              converged <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (iter_nxt == 8'(MAX_ITER)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step_en <= 1'b1;
              state   <= KICK;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.step_en   = step_en;
  assign bus.alpha_set = alpha_set;
  assign bus.policy    = policy;
  assign bus.iter_cnt  = iter_cnt;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.converged = converged;

endmodule

// File: doc/pbvi_loop_ctrl.md
# pbvi_loop_ctrl

Iteration controller and alpha-set store for the PBVI backup pipeline. Responsibilities:
- Kicks off one backup pass per iteration.
- Captures the per-point alpha vectors and action choices emitted at the end of the argmax stage, signalled by the one-cycle `en_loop` pulse.
- Compares the new alpha set against the stored one, commits it, and either re-launches the pipeline or stops on convergence or iteration limit.

It sits at the output end of the argmax stage and drives the start of the next pass.

## Interface
Parameters:
- `N_POINTS`, 16, number of belief points
- `N_STATES`, 2, alpha vector length
- `W`, 16, unsigned datapath width
- `MAX_ITER`, 64, iteration cap (1..255)
- `EPS`, 16'd4, convergence threshold on max absolute element delta
- `TIMEOUT`, 255, `WAIT` watchdog length in cycles (only with the macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle solve request
- `en_loop`  in  1  one-cycle pulse: `alpha_in`/`action_in` valid
- `alpha_in`  in  W×N_POINTS×N_STATES  new alpha vectors, `[point][state]`
- `action_in`  in  2×N_POINTS  new argmax action per point
- `step_en`  out  1  one-cycle pulse launching a backup pass
- `alpha_set`  out  W×N_POINTS×N_STATES  committed alpha set (registered)
- `policy`  out  2×N_POINTS  committed action per point (registered)
- `iter_cnt`  out  8  committed iterations
- `busy`  out  1  high in any state except `IDLE`
- `done`  out  1  one-cycle pulse at solve end
- `converged`  out  1  level; set on convergence, cleared by `start`
- `timeout`  out  1  level; watchdog fired, cleared by `start`

## Operation
States: `IDLE`, `KICK`, `WAIT`, `CMP`, `DONE`.

- **`IDLE`**
  - On `start`: clear `iter_cnt`, `converged` and `timeout`, then go to `KICK`.
  - `alpha_set` and `policy` keep their values; they are not cleared by `start`, so the previous solve seeds the next.
- **`KICK`**
  - `step_en` = 1 for exactly this cycle, then go to `WAIT`.
- **`WAIT`**
  - On `en_loop`: capture `alpha_in` and `action_in` into shadow registers `alpha_new` and `pol_new`, zero `max_delta` and `idx`, then go to `CMP`.
- **`CMP`**
  - One point per cycle, `idx` 0..N_POINTS-1.
  - For each state s: `d = (new≥old) ? new-old : old-new`, unsigned W bits, no wrap.
  - `max_delta <= max(max_delta, d[0], d[1])`.
  - On the last `idx`, commit all of the following on the same edge: `alpha_set <= alpha_new`, `policy <= pol_new`, `iter_cnt <= iter_cnt+1`.
  - Next state on that edge:
    - final max ≤ `EPS` → set `converged`, go to `DONE`;
    - else `iter_cnt+1 == MAX_ITER` → go to `DONE`;
    - else → go to `KICK`.
  - The comparison uses the final max, including the last point.
- **`DONE`**
  - `done` = 1 for this cycle, then go to `IDLE`.

Boundary rules:
- `start` while `busy`: ignored.
- `en_loop` outside `WAIT`: ignored, no capture.
- `en_loop` in the same cycle as the `KICK` → `WAIT` transition: not captured.
- First iteration after reset compares against the all-zero `alpha_set`.
- `rst_n` low at any time aborts and clears every register.
- Reset values: `step_en`, `done`, `busy`, `converged`, `timeout` = 0; `alpha_set` = 0; `policy` = 0; `iter_cnt` = 0; state = `IDLE`.

## Timing
- `start` sampled high at edge T → `KICK` at T, `step_en` high in cycle T..T+1.
- `en_loop` sampled at edge E → `CMP` occupies E..E+N_POINTS.
  - Commit at edge E+N_POINTS.
  - Next `step_en` in cycle E+N_POINTS..E+N_POINTS+1, i.e. 17 cycles after `en_loop` for defaults.
- `done` asserts the cycle after the commit edge; `converged` is valid when `done` is high.
- Outputs change only on clock edges except under async reset.

## Configuration
`PBVI_LOOP_TIMEOUT_EN`:
- **Defined:**
  - A counter runs in `WAIT`.
  - If `TIMEOUT` cycles pass without `en_loop`: set `timeout`, go to `DONE`, no commit.
  - An `en_loop` on the final count cycle wins over the timeout.
- **Undefined:**
  - `WAIT` is unbounded.
  - `timeout` is tied to 0.

## Test plan
- **Reset:** after `rst_n` release, all outputs are 0 and the state is `IDLE`; `en_loop` pulses give no capture and `alpha_set` stays 0.
- **Single-iteration convergence:** `alpha_in` all 16'd3, `start`, then `en_loop` 5 cycles after `step_en`
  - → max delta 3 ≤ 4;
  - `done` 17 cycles after `en_loop`;
  - `converged` = 1, `iter_cnt` = 1, `alpha_set` all 3.
- **Multi-iteration:** iteration 1 `alpha_in` = 100; iteration 2 = 102; `policy_in` = 2'b10 everywhere
  - → exactly 2 `step_en` pulses;
  - `converged` = 1, `iter_cnt` = 2, `policy` all 2'b10.
- **Iteration cap:** `MAX_ITER` = 3, `alpha_in` = 10×iter (never converges)
  - → 3 `step_en` pulses;
  - `done` with `converged` = 0, `iter_cnt` = 3.
- **Protocol abuse:** `start` during `CMP` and `en_loop` during `KICK`
  - → both ignored; the run completes identically to the clean run.
- **Timeout (macro on, `TIMEOUT` = 8):** no `en_loop` after `step_en`
  - → `done` and `timeout` = 1 nine cycles after `step_en`;
  - `alpha_set` unchanged, `iter_cnt` = 0.
  - Mid-`WAIT` `rst_n` pulse → all outputs return to 0.
